mux_rr_reg: RTL and testbench

Parametrised successor to the single-bit registered 2:1 mux. Selects one of NCH input channels of WIDTH bits with per-channel valid/ready handshakes. Two selection modes: direct select, or round-robin arbitration. The result goes into a single registered output stage with valid/ready, and the stage sustains one transfer per cycle. Sits between multiple producer stages and one shared consumer in the datapath.

---
 rtl/mux_rr_reg_pkg.sv | 12 +
 rtl/mux_defs.vh | 6 +
 rtl/mux_rr_reg_rr_pick.sv | 31 +++
 rtl/mux_rr_reg.sv | 93 +++++++++
 tb/tb_mux_rr_reg.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_reg_pkg.sv
// rtl/mux_rr_reg_pkg.sv - shared defaults and index helper for the channel mux
package mux_rr_reg_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int NCH_DEFAULT   = 4;

  // Channel index reached k steps after base, wrapping modulo n.
  function automatic int rot_idx(input int base, input int k, input int n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/mux_defs.vh
// rtl/mux_defs.vh - mode encodings shared by the channel mux
`ifndef MUX_DEFS_VH
`define MUX_DEFS_VH
`define MODE_FIXED 1'b0
`define MODE_RR    1'b1
`endif

// File: rtl/mux_rr_reg_rr_pick.sv
// rtl/mux_rr_reg_rr_pick.sv - combinational rotating-priority picker
// Scans req starting one past last, wrapping; reports the first set index.
module rr_pick
  import mux_rr_reg_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] last,
  output logic            any,
  output logic [SELW-1:0] idx
);

  int pos;

  // Walk from farthest to nearest so the closest requester overwrites the rest.
  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = 0;
    for (int k = NCH; k >= 1; k--) begin
      pos = rot_idx(int'(last), k, NCH);
      if (req[pos]) begin
        any = 1'b1;
        idx = SELW'(pos);
      end
    end
  end

endmodule

// File: rtl/mux_rr_reg.sv
// rtl/mux_rr_reg.sv - NCH:1 channel mux (direct or round-robin) into one registered valid/ready stage
`include "mux_defs.vh"
module mux_rr_reg
  import mux_rr_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int NCH   = NCH_DEFAULT,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [SELW:0] NCH_CMP = (SELW+1)'(NCH);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  last_q, last_d;

  logic             rr_any;
  logic [SELW-1:0]  rr_idx;
  logic             load_en;
  logic             fix_req;
  logic             req;
  logic             xfer;
  logic [SELW-1:0]  choice;

  rr_pick #(.NCH(NCH)) u_pick (
    .req  (in_valid),
    .last (last_q),
    .any  (rr_any),
    .idx  (rr_idx)
  );

  always_comb begin
    load_en = !valid_q || out_ready;
    fix_req = ({1'b0, sel} < NCH_CMP) && in_valid[sel];
    choice  = (mode == `MODE_RR) ? rr_idx : sel;
    req     = (mode == `MODE_RR) ? rr_any : fix_req;
    // Reset gating keeps in_ready low while the register is held clear.
    xfer    = !reset && load_en && req;
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = xfer && (choice == SELW'(i));
    end
  end

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (xfer) begin
      data_d  = in_data[choice*WIDTH +: WIDTH];
      ch_d    = choice;
      valid_d = 1'b1;
      if (mode == `MODE_RR) begin
        last_d = choice;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= SELW'(NCH - 1);
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// tb/tb_mux_rr_reg.sv - directed and randomized checks of mux_rr_reg against a reference model
module tb_mux_rr_reg;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_ch;
  int               m_last;

  mux_rr_reg #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel the rules grant this cycle, or -1 when nothing may transfer.
  function automatic int model_grant();
    if (reset) return -1;
    if (m_valid && !out_ready) return -1;
    if (mode) begin
      for (int k = 1; k <= NCH; k++) begin
        if (in_valid[(m_last + k) % NCH]) return (m_last + k) % NCH;
      end
      return -1;
    end
    if (int'(sel) < NCH && in_valid[sel]) return int'(sel);
    return -1;
  endfunction

  function automatic logic [NCH-1:0] model_ready();
    int g;
    g = model_grant();
    return (g < 0) ? '0 : NCH'(1 << g);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    m_last  = NCH - 1;
  endtask

  // One clock: check handshake, advance model and DUT, check registered outputs.
  task automatic cyc(input string tag);
    int g;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(model_ready()));
    g = model_grant();
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = in_data[g*WIDTH +: WIDTH];
      m_ch    = g;
      if (mode) m_last = g;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, "_out_data"}, 32'(out_data), 32'(m_data));
      chk({tag, "_out_ch"}, 32'(out_ch), 32'(m_ch));
    end
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    logic [SELW-1:0] rr_seq [6];
    logic [SELW-1:0] alt_seq [3];
    rr_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    alt_seq = '{2'd3, 2'd1, 2'd3};

    reset = 1'b1; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    model_reset();
    @(posedge clk); #2 reset = 1'b0;

    // Async reset between edges
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    in_data = {8'h00, 8'h00, 8'h00, 8'h3C}; in_valid = 4'b0001; sel = 2'd0;
    cyc("load3c");
    chk("load3c_data", 32'(out_data), 32'h3C);
    #2 reset = 1'b1; model_reset();
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_data", 32'(out_data), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_in_ready", 32'(in_ready), 32'd0);
    #1 reset = 1'b0;

    // Direct select of channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    in_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    #1 chk("fix2_in_ready", 32'(in_ready), 32'h4);
    cyc("fix2");
    chk("fix2_data", 32'(out_data), 32'hA5);
    chk("fix2_ch", 32'(out_ch), 32'd2);

    // Backpressure
    sel = 2'd0; in_valid = 4'b0001; in_data = {8'h00, 8'h00, 8'h00, 8'h11};
    cyc("bp_load");
    out_ready = 1'b0; in_data = {8'h00, 8'h00, 8'h00, 8'h22};
    for (int i = 0; i < 3; i++) begin
      cyc("bp_stall");
      chk("bp_hold_data", 32'(out_data), 32'h11);
    end
    out_ready = 1'b1;
    cyc("bp_release");
    chk("bp_release_data", 32'(out_data), 32'h22);

    // Round-robin from reset with all channels valid
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 6; i++) begin
      cyc("rr_all");
      chk("rr_all_seq", 32'(out_ch), 32'(rr_seq[i]));
    end

    // Last grant was channel 1; alternate between channels 3 and 1
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      cyc("rr_alt");
      chk("rr_alt_seq", 32'(out_ch), 32'(alt_seq[i]));
    end

    // Unrequested fixed channel, then pointer survives a fixed-mode transfer
    mode = 1'b0; sel = 2'd1; in_valid = 4'b1101;
    #1 chk("fix_none_in_ready", 32'(in_ready), 32'd0);
    cyc("fix_none");
    chk("fix_none_drain", 32'(out_valid), 32'd0);
    sel = 2'd2; in_valid = 4'b0100;
    cyc("fix_keep_ptr");
    mode = 1'b1; in_valid = 4'b1111;
    cyc("rr_resume");
    chk("rr_resume_ch", 32'(out_ch), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = SELW'($urandom_range(0, NCH - 1));
      in_valid  = NCH'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
